// File: rtl/encoder4_2_sync_if.sv
// Request/handshake bundle for the registered 4-to-2 priority encoder.
// The master side drives the request lines and ack, and the slave side drives the result.
interface encoder4_2_sync_if;
    logic [3:0] in_n;
    logic       ack;
    logic [1:0] code;
    logic       valid;
    logic       multi;
    logic       busy;

    modport master (
        output in_n,
        output ack,
        input  code,
        input  valid,
        input  multi,
        input  busy
    );

    modport slave (
        input  in_n,
        input  ack,
        output code,
        output valid,
        output multi,
        output busy
    );
endinterface

// File: rtl/encoder4_2_sync.sv
// Debounced, registered 4-to-2 priority encoder with a valid/ack handshake.
// It reports one event per press. Defining ENC_SYNC_EN adds a 2-flop input synchronizer.
module encoder4_2_sync #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    encoder4_2_sync_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_DEBOUNCE = 2'b01,
        ST_VALID    = 2'b10,
        ST_RELEASE  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    // The highest active index wins.
    function automatic logic [1:0] prio_code(input logic [3:0] act);
        logic [1:0] c;
        if (act[3]) begin
            c = 2'd3;
        end else if (act[2]) begin
            c = 2'd2;
        end else if (act[1]) begin
            c = 2'd1;
        end else begin
            c = 2'd0;
        end
        return c;
    endfunction

    function automatic logic more_than_one(input logic [3:0] act);
        return ((act & (act - 4'd1)) != 4'd0);
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cap_q, cap_d;
    logic [1:0]       code_q, code_d;
    logic             multi_q, multi_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [3:0]       samp_s;
    logic [3:0]       active_s;

`ifdef ENC_SYNC_EN
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;

    // Two-flop synchronizer for asynchronous switch lines
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 4'b1111;
            sync2_q <= 4'b1111;
        end else begin
            sync1_q <= bus.in_n;
            sync2_q <= sync1_q;
        end
    end

    assign samp_s = sync2_q;
`else
    assign samp_s = bus.in_n;
`endif

    assign active_s = ~samp_s;

    // Next-state, debounce counter and result capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        code_d  = code_q;
        multi_d = multi_q;
        case (state_q)
            ST_IDLE: begin
                if (active_s != 4'd0) begin
                    cap_d   = samp_s;
                    cnt_d   = '0;
                    state_d = ST_DEBOUNCE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DEBOUNCE: begin
                if (samp_s != cap_q) begin
                    if (active_s == 4'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cap_d = samp_s;
                        cnt_d = '0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_VALID;
                    code_d  = prio_code(~cap_q);
                    multi_d = more_than_one(~cap_q);
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_VALID: begin
                if (bus.ack) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_VALID;
                end
            end
            ST_RELEASE: begin
                // Held lines must be fully released before a new press can register.
                if (active_s == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                cap_d   = 4'b1111;
            end
        endcase
        valid_d = (state_d == ST_VALID);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cap_q   <= 4'b1111;
            code_q  <= 2'b00;
            multi_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            code_q  <= code_d;
            multi_q <= multi_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.code  = code_q;
    assign bus.multi = multi_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_encoder4_2_sync.sv
// Directed self-checking bench for encoder4_2_sync (DEB_CYCLES=4).
module tb_encoder4_2_sync;

    localparam int DEB = 4;
`ifdef ENC_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int LAT = DEB + SYNC_LAT;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   vcount;

    encoder4_2_sync_if ifc ();

    encoder4_2_sync #(.DEB_CYCLES(DEB), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply a pattern and expect valid to rise exactly LAT edges after the first sample.
    task automatic run_press(input string tag, input logic [3:0] pat,
                             input logic [1:0] exp_code, input logic exp_multi);
        ifc.in_n = pat;
        for (int i = 0; i < LAT; i++) begin
            tick();
            chk({tag, "_early_valid"}, {3'b000, ifc.valid}, 4'd0);
        end
        tick();
        chk({tag, "_valid"}, {3'b000, ifc.valid}, 4'd1);
        chk({tag, "_code"},  {2'b00, ifc.code},   {2'b00, exp_code});
        chk({tag, "_multi"}, {3'b000, ifc.multi}, {3'b000, exp_multi});
        chk({tag, "_busy"},  {3'b000, ifc.busy},  4'd1);
    endtask

    task automatic ack_release(input string tag, input logic [1:0] exp_code);
        ifc.ack = 1'b1;
        tick();
        ifc.ack = 1'b0;
        chk({tag, "_valid_drop"}, {3'b000, ifc.valid}, 4'd0);
        chk({tag, "_code_kept"},  {2'b00, ifc.code},   {2'b00, exp_code});
        ifc.in_n = 4'b1111;
        for (int i = 0; i < SYNC_LAT + 1; i++) tick();
        chk({tag, "_idle"}, {3'b000, ifc.busy}, 4'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        ifc.in_n = 4'b1111;
        ifc.ack  = 1'b0;

        // Reset and idle
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_code",  {2'b00, ifc.code},   4'd0);
            chk("rst_valid", {3'b000, ifc.valid}, 4'd0);
            chk("rst_multi", {3'b000, ifc.multi}, 4'd0);
            chk("rst_busy",  {3'b000, ifc.busy},  4'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_busy",  {3'b000, ifc.busy},  4'd0);
            chk("idle_valid", {3'b000, ifc.valid}, 4'd0);
        end

        // Single press: valid is held until ack
        run_press("single", 4'b1011, 2'b10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("single_hold_valid", {3'b000, ifc.valid}, 4'd1);
        end
        ack_release("single", 2'b10);

        // Multiple lines with priority, then the lowest line alone
        run_press("multi", 4'b0110, 2'b11, 1'b1);
        ack_release("multi", 2'b11);
        run_press("low", 4'b1110, 2'b00, 1'b0);
        ack_release("low", 2'b00);

        // Bounce: the pattern never stays stable long enough
        for (int p = 0; p < 5; p++) begin
            ifc.in_n = (p % 2 == 0) ? 4'b1101 : 4'b1111;
            for (int i = 0; i < 2; i++) begin
                tick();
                chk("bounce_valid", {3'b000, ifc.valid}, 4'd0);
            end
        end
        ifc.in_n = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bounce_valid", {3'b000, ifc.valid}, 4'd0);
        end
        chk("bounce_idle", {3'b000, ifc.busy}, 4'd0);
        run_press("stable", 4'b1101, 2'b01, 1'b0);
        ack_release("stable", 2'b01);

        // Lines held after ack never re-trigger
        run_press("hold", 4'b1110, 2'b00, 1'b0);
        ifc.ack = 1'b1;
        tick();
        ifc.ack = 1'b0;
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ifc.valid) vcount++;
        end
        chk("hold_no_retrigger", vcount[3:0], 4'd0);
        chk("hold_busy", {3'b000, ifc.busy}, 4'd1);
        ifc.in_n = 4'b1111;
        for (int i = 0; i < SYNC_LAT + 1; i++) tick();
        chk("hold_idle", {3'b000, ifc.busy}, 4'd0);
        run_press("repress", 4'b1110, 2'b00, 1'b0);
        ack_release("repress", 2'b00);

        // Ack held high is ignored until valid, then valid lasts one cycle
        ifc.ack = 1'b1;
        tick();
        chk("ack_idle_valid", {3'b000, ifc.valid}, 4'd0);
        run_press("ackhigh", 4'b0111, 2'b11, 1'b0);
        vcount = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ifc.valid) vcount++;
        end
        chk("ackhigh_one_cycle", vcount[3:0], 4'd0);
        ifc.ack = 1'b0;
        ifc.in_n = 4'b1111;
        for (int i = 0; i < SYNC_LAT + 1; i++) tick();
        chk("ackhigh_idle", {3'b000, ifc.busy}, 4'd0);
        chk("ackhigh_code_kept", {2'b00, ifc.code}, 4'd3);

        // Reset during debounce aborts cleanly
        ifc.in_n = 4'b1011;
        for (int i = 0; i < LAT - 2; i++) tick();
        chk("deb_busy", {3'b000, ifc.busy}, 4'd1);
        rst_n = 1'b0;
        tick();
        chk("midrst_busy",  {3'b000, ifc.busy},  4'd0);
        chk("midrst_valid", {3'b000, ifc.valid}, 4'd0);
        chk("midrst_code",  {2'b00, ifc.code},   4'd0);
        rst_n = 1'b1;
        ifc.in_n = 4'b1111;
        for (int i = 0; i < LAT + 2; i++) begin
            tick();
            chk("postrst_valid", {3'b000, ifc.valid}, 4'd0);
        end
        run_press("postrst", 4'b1011, 2'b10, 1'b0);
        ack_release("postrst", 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/encoder4_2_sync.md
Name: encoder4_2_sync

Overview:
- Registered 4-to-2 priority encoder. It is the return path for the team's active-low 2-to-4 decoder: it takes four active-low request lines (line k low = code k) and produces a 2-bit code.
- Built-in debounce and a valid/ack handshake, so switch or keypad lines on the lab board can drive downstream logic cleanly.
- One event per press: after ack, nothing new is reported until all lines are released.

Parameters:
- DEB_CYCLES, default 4: consecutive clock edges the active pattern must stay unchanged before it is reported. Legal range 1..65535.
- CNT_W, default 16: debounce counter width. Must satisfy 2^CNT_W > DEB_CYCLES.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active low.
- in_n  input  4  request lines, active low. in_n[0] maps to code 00, in_n[3] maps to code 11.
- ack  input  1  consumer acknowledge, sampled only while valid=1.
- code  output  2  encoded index of the highest-numbered active line.
- valid  output  1  code/multi are stable and reportable.
- multi  output  1  more than one line was active in the captured pattern.
- busy  output  1  FSM is not in IDLE.

Behaviour:
- Clocking and reset
  - Single clock domain. Reset is synchronous and active-low, sampled on rising clk.
  - Reset values: code=2'b00, valid=0, multi=0, busy=0, FSM=IDLE, counter=0, captured pattern=4'b1111.
  - Reset asserted mid-operation: abort immediately at that edge, no partial output.
- Sampling and encoding
  - All outputs are registered; there is no combinational path from in_n to the outputs.
  - s = sampled in_n (direct, or synchronized per the optional feature). active = ~s.
  - Priority: highest active index wins. active=4'b0101 gives code=2'b10 and multi=1.
- FSM states: IDLE, DEBOUNCE, VALID, RELEASE.
  - IDLE: if active!=0, capture s, set counter=0, go to DEBOUNCE. Otherwise stay.
  - DEBOUNCE:
    - s != captured and active==0: go to IDLE.
    - s != captured and active!=0: recapture, set counter=0, stay in DEBOUNCE.
    - s == captured and counter==DEB_CYCLES-1: go to VALID and load code/multi from the captured pattern.
    - Otherwise: counter+1.
  - VALID:
    - valid=1. code/multi are held constant regardless of in_n.
    - ack=1 sampled while valid=1: go to RELEASE, valid=0 at the same edge.
    - Releasing the lines without ack does not drop valid.
  - RELEASE: wait for active==0 at one edge, then go to IDLE. Lines that stay held never re-trigger.
- Latency: first edge sampling a stable pattern is edge 0; valid rises after edge DEB_CYCLES.
- Handshake
  - ack while valid=0 is ignored.
  - ack held high continuously acknowledges each event on its first valid cycle, so valid is high for exactly 1 cycle.
- code/multi keep their last reported value after valid falls, until the next capture into VALID.
- Counter saturation is impossible by parameter rule; counter wrap is a design error.

Optional Feature:
- Macro: ENC_SYNC_EN.
- Defined: in_n passes through a 2-flop synchronizer, reset to 4'b1111. s is the second flop. Total latency from the in_n change is DEB_CYCLES+2 edges.
- Undefined: s = in_n directly. Latency is DEB_CYCLES edges.
- FSM and ports are identical in both builds.

Test Plan:
(DEB_CYCLES=4, ENC_SYNC_EN undefined)
- Reset then idle: rst_n=0 for 2 cycles, in_n=4'b1111 → code=00, valid=0, multi=0, busy=0 throughout.
- Single press: in_n=4'b1011 held, ack=0 → valid=1 after the 4th edge following the first sample, code=10, multi=0, busy=1. Valid stays high until ack=1 for one cycle, then valid=0.
- Multi press plus priority: in_n=4'b0110 → code=11, multi=1. Release after ack, then in_n=4'b1110 → code=00, multi=0.
- Bounce: in_n toggles 1101/1111 every 2 cycles for 10 cycles → valid never rises. Then 1101 held 4 edges → valid=1, code=01.
- Hold after ack: in_n=4'b1110 held 20 cycles, ack pulsed once → exactly one valid event. After release to 1111 and re-press, a second event with code=00.
- Reset mid-debounce and ENC_SYNC_EN build:
  - rst_n=0 during DEBOUNCE → next edge busy=0, valid=0.
  - Rebuild with ENC_SYNC_EN: the same single-press case gives valid 2 edges later (6 total).
